// File: rtl/fork_join_ctrl.sv
// Fork/join scheduler: broadcasts one request to NUM_LANES lanes, collects the
// first result from each lane, and returns their modular sum under a watchdog.
module fork_join_ctrl #(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned W         = 8,
  parameter int unsigned TW        = 8,
  parameter int unsigned TIMEOUT   = 200
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [W-1:0]           req_data,
  output logic [NUM_LANES-1:0]   lane_start,
  output logic [W-1:0]           lane_data,
  input  logic [NUM_LANES-1:0]   lane_done,
  input  logic [NUM_LANES*W-1:0] lane_result,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [W-1:0]           resp_data,
  output logic                   resp_err,
  output logic                   busy
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, JOIN, RESP} state_t;

  localparam bit              WD_EN      = (TIMEOUT != 0);
  localparam logic [TW-1:0]   TIMER_MAX  = '1;
  localparam logic [TW-1:0]   TIMER_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t                 state, state_nxt;
  logic [NUM_LANES-1:0]   mask, mask_nxt;
  logic [W-1:0]           results [NUM_LANES];
  logic [TW-1:0]          timer;
  logic                   err_flag;
  logic [W-1:0]           sum;
  logic                   all_done, timed_out;

  assign req_ready  = (state == IDLE);
  assign lane_start = {NUM_LANES{state == ISSUE}};
  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);

  // Completion looks at bits landing this cycle so a lane finishing on the
  // watchdog's last cycle still counts as a clean join.
  always_comb begin
    mask_nxt  = mask | lane_done;
    all_done  = &mask_nxt;
    timed_out = WD_EN && (timer == TIMER_LAST);
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (all_done || timed_out) state_nxt = JOIN;
      JOIN:    state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      sum = sum + results[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_data <= '0;
      mask      <= '0;
      timer     <= '0;
      err_flag  <= 1'b0;
      resp_data <= '0;
      resp_err  <= 1'b0;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        results[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) lane_data <= req_data;
        end
        ISSUE: begin
          mask  <= '0;
          timer <= '0;
          for (int unsigned i = 0; i < NUM_LANES; i++) begin
            results[i] <= '0;
          end
        end
        WAIT: begin
          for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (lane_done[i] && !mask[i]) results[i] <= lane_result[i*W +: W];
          end
          mask <= mask_nxt;
          if (timer != TIMER_MAX) timer <= timer + 1'b1;
          // Only the value written on the exit cycle is ever consumed.
          err_flag <= !all_done;
        end
        JOIN: begin
          resp_data <= sum;
          resp_err  <= err_flag;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fork_join_ctrl.sv
// Bench for fork_join_ctrl: two instances (long and short watchdog) share one
// stimulus path selected by sel; results are checked against a schedule model.
module tb_fork_join_ctrl;
  localparam int N = 4;
  localparam int W = 8;
  localparam int TO_A = 200;
  localparam int TO_B = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           sel = 1'b0;
  logic           req_valid = 1'b0, resp_ready = 1'b0;
  logic [W-1:0]   req_data = '0;
  logic [N-1:0]   lane_done = '0;
  logic [N*W-1:0] lane_result = '0;

  logic a_req_valid, b_req_valid, a_resp_ready, b_resp_ready;
  logic [N-1:0] a_lane_done, b_lane_done;
  logic a_req_ready, b_req_ready, a_resp_valid, b_resp_valid;
  logic a_resp_err, b_resp_err, a_busy, b_busy;
  logic [N-1:0] a_lane_start, b_lane_start;
  logic [W-1:0] a_lane_data, b_lane_data, a_resp_data, b_resp_data;

  logic req_ready, resp_valid, resp_err, busy;
  logic [N-1:0] lane_start;
  logic [W-1:0] lane_data, resp_data;

  assign a_req_valid  = req_valid & ~sel;
  assign b_req_valid  = req_valid & sel;
  assign a_resp_ready = resp_ready & ~sel;
  assign b_resp_ready = resp_ready & sel;
  assign a_lane_done  = sel ? '0 : lane_done;
  assign b_lane_done  = sel ? lane_done : '0;

  assign req_ready  = sel ? b_req_ready  : a_req_ready;
  assign resp_valid = sel ? b_resp_valid : a_resp_valid;
  assign resp_err   = sel ? b_resp_err   : a_resp_err;
  assign busy       = sel ? b_busy       : a_busy;
  assign lane_start = sel ? b_lane_start : a_lane_start;
  assign lane_data  = sel ? b_lane_data  : a_lane_data;
  assign resp_data  = sel ? b_resp_data  : a_resp_data;

  fork_join_ctrl #(.NUM_LANES(N), .W(W), .TW(8), .TIMEOUT(TO_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_data(req_data), .lane_start(a_lane_start), .lane_data(a_lane_data),
    .lane_done(a_lane_done), .lane_result(lane_result), .resp_valid(a_resp_valid),
    .resp_ready(a_resp_ready), .resp_data(a_resp_data), .resp_err(a_resp_err),
    .busy(a_busy));

  fork_join_ctrl #(.NUM_LANES(N), .W(W), .TW(8), .TIMEOUT(TO_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_data(req_data), .lane_start(b_lane_start), .lane_data(b_lane_data),
    .lane_done(b_lane_done), .lane_result(lane_result), .resp_valid(b_resp_valid),
    .resp_ready(b_resp_ready), .resp_data(b_resp_data), .resp_err(b_resp_err),
    .busy(b_busy));

  int checks = 0;
  int failures = 0;

  // Schedule: lane i first strobes in WAIT cycle first_cyc[i] (0 = never),
  // plus one extra strobe rep_lane/rep_cyc; cycle 0 is the ISSUE cycle.
  int           first_cyc [N];
  logic [W-1:0] first_val [N];
  int           rep_lane = -1;
  int           rep_cyc = 0;
  logic [W-1:0] rep_val = '0;
  bit           issue_junk = 1'b0;

  bit           accept_ok, start_ok, stable, busy_ok, hs_rr, post_rv, post_rr, post_busy;
  int           got_cyc, start_cycles;
  logic [W-1:0] got_data, got_lane_data;
  logic         got_err;

  function automatic void model(input int to, output int n, output logic [W-1:0] sum,
                                output logic err);
    int eff [N];
    logic [W-1:0] v [N];
    int last;
    bit never;
    last = 0;
    never = 1'b0;
    sum = '0;
    for (int i = 0; i < N; i++) begin
      eff[i] = first_cyc[i];
      v[i] = first_val[i];
      if (rep_lane == i && rep_cyc > 0 && (eff[i] == 0 || rep_cyc < eff[i])) begin
        eff[i] = rep_cyc;
        v[i] = rep_val;
      end
      if (eff[i] == 0) never = 1'b1;
      else if (eff[i] > last) last = eff[i];
    end
    if (to != 0 && (never || last > to)) begin
      n = to;
      err = 1'b1;
    end else begin
      n = last;
      err = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (eff[i] != 0 && eff[i] <= n) sum = sum + v[i];
    end
  endfunction

  task automatic drive_lanes(input int k);
    logic [N-1:0] dn;
    logic [N*W-1:0] r;
    dn = '0;
    r = $urandom;
    if (k == 0) begin
      if (issue_junk) dn = '1;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (first_cyc[i] == k) begin
          dn[i] = 1'b1;
          r[i*W +: W] = first_val[i];
        end
      end
      if (rep_lane >= 0 && rep_cyc == k) begin
        dn[rep_lane] = 1'b1;
        r[rep_lane*W +: W] = rep_val;
      end
    end
    lane_done = dn;
    lane_result = r;
  endtask

  task automatic drive_txn(input logic [W-1:0] d, input int hold);
    bit seen;
    got_cyc = 0;
    start_cycles = 0;
    start_ok = 1'b0;
    stable = 1'b1;
    busy_ok = 1'b1;
    accept_ok = 1'b0;
    seen = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_data = d;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin
        accept_ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_data = W'($urandom);
    for (int c = 1; c <= 400 && !seen; c++) begin
      if (c > 1) begin
        @(posedge clk); #1;
      end
      drive_lanes(c - 1);
      @(negedge clk);
      if (lane_start != '0) start_cycles++;
      if (c == 1) begin
        start_ok = (lane_start == '1);
        got_lane_data = lane_data;
      end
      if (!busy) busy_ok = 1'b0;
      if (resp_valid) begin
        seen = 1'b1;
        got_cyc = c;
      end
    end
    got_data = resp_data;
    got_err = resp_err;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      lane_done = N'($urandom);
      lane_result = $urandom;
      @(negedge clk);
      if (!resp_valid || resp_data !== got_data || resp_err !== got_err || req_ready)
        stable = 1'b0;
    end
    @(posedge clk); #1;
    lane_done = '0;
    resp_ready = 1'b1;
    @(negedge clk);
    hs_rr = req_ready;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
    post_rv = resp_valid;
    post_rr = req_ready;
    post_busy = busy;
  endtask

  task automatic test_reset;
    #12;
    sel = 1'b0;
    checks++;
    if ({req_ready, lane_start, lane_data, resp_valid, resp_data, resp_err, busy} !==
        {1'b1, 4'h0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_a got rr=%b ls=%h ld=%h rv=%b rd=%h re=%b bz=%b", req_ready,
               lane_start, lane_data, resp_valid, resp_data, resp_err, busy);
    end
    sel = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_b got rr=%b bz=%b rv=%b exp 1 0 0", req_ready, busy, resp_valid);
    end
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_join;
    sel = 1'b0;
    for (int i = 0; i < N; i++) begin
      first_cyc[i] = 1;
      first_val[i] = W'(i + 1);
    end
    rep_lane = -1;
    rep_cyc = 0;
    issue_junk = 1'b1;
    drive_txn(8'h10, 0);
    issue_junk = 1'b0;
    checks++;
    if (!accept_ok || !start_ok || start_cycles != 1) begin
      failures++;
      $display("FAIL basic_start got acc=%b full=%b cycles=%0d exp 1 1 1", accept_ok,
               start_ok, start_cycles);
    end
    checks++;
    if (got_lane_data !== 8'h10) begin
      failures++;
      $display("FAIL basic_lane_data got=%h exp=10", got_lane_data);
    end
    checks++;
    if (got_cyc != 4) begin
      failures++;
      $display("FAIL basic_latency got=%0d exp=4", got_cyc);
    end
    checks++;
    if (got_data !== 8'h0A || got_err !== 1'b0) begin
      failures++;
      $display("FAIL basic_resp got data=%h err=%b exp data=0a err=0", got_data, got_err);
    end
    checks++;
    if (hs_rr !== 1'b0 || post_rv !== 1'b0 || post_rr !== 1'b1) begin
      failures++;
      $display("FAIL basic_handoff got hs_rr=%b rv=%b rr=%b exp 0 0 1", hs_rr, post_rv,
               post_rr);
    end
  endtask

  task automatic test_staggered;
    sel = 1'b0;
    first_cyc[0] = 1; first_cyc[1] = 3; first_cyc[2] = 3; first_cyc[3] = 7;
    for (int i = 0; i < N; i++) first_val[i] = 8'h80;
    rep_lane = 0;
    rep_cyc = 5;
    rep_val = 8'hFF;
    drive_txn(8'h33, 0);
    checks++;
    if (got_data !== 8'h00 || got_err !== 1'b0) begin
      failures++;
      $display("FAIL stagger_resp got data=%h err=%b exp data=00 err=0", got_data, got_err);
    end
    checks++;
    if (got_cyc != 10) begin
      failures++;
      $display("FAIL stagger_latency got=%0d exp=10", got_cyc);
    end
  endtask

  task automatic test_timeout;
    sel = 1'b1;
    for (int i = 0; i < N; i++) begin
      first_cyc[i] = (i == 2) ? 0 : i + 1;
      first_val[i] = 8'h05;
    end
    rep_lane = 2;
    rep_cyc = 6;
    rep_val = 8'h77;
    drive_txn(8'h5A, 2);
    checks++;
    if (got_data !== 8'h0F || got_err !== 1'b1) begin
      failures++;
      $display("FAIL timeout_resp got data=%h err=%b exp data=0f err=1", got_data, got_err);
    end
    checks++;
    if (got_cyc != TO_B + 3) begin
      failures++;
      $display("FAIL timeout_latency got=%0d exp=%0d", got_cyc, TO_B + 3);
    end
    checks++;
    if (!busy_ok || !stable || post_busy !== 1'b0 || post_rr !== 1'b1) begin
      failures++;
      $display("FAIL timeout_busy got inflight=%b stable=%b after=%b rr=%b exp 1 1 0 1",
               busy_ok, stable, post_busy, post_rr);
    end
  endtask

  task automatic test_tie;
    int n;
    logic [W-1:0] es;
    logic ee;
    sel = 1'b1;
    first_cyc[0] = 2; first_cyc[1] = TO_B; first_cyc[2] = 1; first_cyc[3] = 3;
    for (int i = 0; i < N; i++) first_val[i] = W'($urandom);
    rep_lane = -1;
    rep_cyc = 0;
    model(TO_B, n, es, ee);
    drive_txn(8'hC3, 0);
    checks++;
    if (got_err !== 1'b0 || got_data !== es) begin
      failures++;
      $display("FAIL tie_resp got data=%h err=%b exp data=%h err=0", got_data, got_err, es);
    end
    checks++;
    if (got_cyc != TO_B + 3) begin
      failures++;
      $display("FAIL tie_latency got=%0d exp=%0d", got_cyc, TO_B + 3);
    end
  endtask

  task automatic test_backpressure;
    int n;
    logic [W-1:0] es;
    logic ee;
    sel = 1'b0;
    rep_lane = -1;
    rep_cyc = 0;
    for (int i = 0; i < N; i++) begin
      first_cyc[i] = $urandom_range(1, 4);
      first_val[i] = W'($urandom);
    end
    model(TO_A, n, es, ee);
    drive_txn(W'($urandom), 10);
    checks++;
    if (!stable || got_data !== es || got_err !== ee) begin
      failures++;
      $display("FAIL backpressure got stable=%b data=%h err=%b exp stable=1 data=%h err=%b",
               stable, got_data, got_err, es, ee);
    end
    checks++;
    if (hs_rr !== 1'b0 || post_rr !== 1'b1 || post_rv !== 1'b0) begin
      failures++;
      $display("FAIL backpressure_handoff got hs_rr=%b rr=%b rv=%b exp 0 1 0", hs_rr,
               post_rr, post_rv);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    logic [W-1:0] es;
    logic ee;
    sel = 1'b0;
    rep_lane = -1;
    rep_cyc = 0;
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < N; i++) begin
        first_cyc[i] = $urandom_range(1, 3);
        first_val[i] = W'($urandom);
      end
      model(TO_A, n, es, ee);
      drive_txn(W'($urandom), 0);
      checks++;
      if (!accept_ok || got_cyc != n + 3 || got_data !== es || got_err !== ee) begin
        failures++;
        $display("FAIL b2b_%0d got acc=%b cyc=%0d data=%h err=%b exp 1 %0d %h %b", t,
                 accept_ok, got_cyc, got_data, got_err, n + 3, es, ee);
      end
    end
  endtask

  task automatic test_random;
    int n, to;
    logic [W-1:0] es;
    logic ee;
    for (int t = 0; t < 24; t++) begin
      sel = t[0];
      to = sel ? TO_B : TO_A;
      for (int i = 0; i < N; i++) begin
        first_cyc[i] = sel ? $urandom_range(0, 7) : $urandom_range(1, 8);
        first_val[i] = W'($urandom);
      end
      rep_lane = $urandom_range(0, N - 1);
      rep_cyc = (first_cyc[rep_lane] > 0) ? first_cyc[rep_lane] + $urandom_range(1, 4)
                                          : $urandom_range(1, 9);
      rep_val = W'($urandom);
      issue_junk = $urandom_range(0, 1) == 1;
      model(to, n, es, ee);
      drive_txn(W'($urandom), $urandom_range(0, 3));
      issue_junk = 1'b0;
      checks++;
      if (got_cyc != n + 3 || got_data !== es || got_err !== ee || !stable) begin
        failures++;
        $display("FAIL random_%0d sel=%0d got cyc=%0d data=%h err=%b stable=%b exp %0d %h %b 1",
                 t, sel, got_cyc, got_data, got_err, stable, n + 3, es, ee);
      end
    end
  endtask

  task automatic test_async_reset;
    int n;
    logic [W-1:0] es;
    logic ee;
    sel = 1'b1;
    rep_lane = -1;
    rep_cyc = 0;
    for (int i = 0; i < N; i++) begin
      first_cyc[i] = (i < 2) ? 1 : 0;
      first_val[i] = 8'h40;
    end
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_data = 8'hA5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    drive_lanes(0);
    @(posedge clk); #1;
    drive_lanes(1);
    @(posedge clk); #1;
    drive_lanes(2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, lane_start, lane_data, resp_valid, resp_data, resp_err, busy} !==
        {1'b1, 4'h0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL async_reset got rr=%b ls=%h ld=%h rv=%b rd=%h re=%b bz=%b", req_ready,
               lane_start, lane_data, resp_valid, resp_data, resp_err, busy);
    end
    lane_done = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      first_cyc[i] = (i < 2) ? 0 : 3;
      first_val[i] = 8'h03;
    end
    model(TO_B, n, es, ee);
    drive_txn(8'h11, 0);
    checks++;
    if (got_data !== es || got_err !== ee || got_cyc != n + 3) begin
      failures++;
      $display("FAIL post_reset got data=%h err=%b cyc=%0d exp %h %b %0d", got_data, got_err,
               got_cyc, es, ee, n + 3);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      first_cyc[i] = 0;
      first_val[i] = '0;
    end
    test_reset();
    test_basic_join();
    test_staggered();
    test_timeout();
    test_tie();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
